// File: rtl/multicore_pkg.sv
// Shared types for the execute-stage M-extension unit: operation codes,
// FSM states and datapath defaults.
package multicore_pkg;

  localparam int unsigned NUM_REGS          = 32;
  localparam int unsigned MD_BITS_PER_CYCLE = 1;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } t_mdop;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } t_md_state;

  function automatic logic md_is_div(input t_mdop op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*DATA_SIZE working register; signs are handled by the caller.
module md_iter_core #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                     i_aclk,
  input  logic                     i_areset_n,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic                     i_is_div,
  input  logic [DATA_SIZE-1:0]     i_a_mag,
  input  logic [DATA_SIZE-1:0]     i_b_mag,
  output logic [2*DATA_SIZE-1:0]   o_pq
);

  localparam int unsigned W = DATA_SIZE;

  logic [2*W-1:0] r_pq;
  logic [W-1:0]   r_opd;
  logic           r_is_div;
  logic [2*W-1:0] w_pq;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;

  // Low half starts as multiplier (mul) or dividend (div); high half is the
  // running partial product / remainder.
  always_comb begin
    w_pq   = r_pq;
    w_sum  = '0;
    w_diff = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_is_div) begin
        w_diff = w_pq[2*W-1:W-1] - {1'b0, r_opd};
        if (!w_diff[W])
          w_pq = {w_diff[W-1:0], w_pq[W-2:0], 1'b1};
        else
          w_pq = {w_pq[2*W-2:0], 1'b0};
      end else begin
        w_sum = {1'b0, w_pq[2*W-1:W]} + (w_pq[0] ? {1'b0, r_opd} : '0);
        w_pq  = {w_sum, w_pq[W-1:1]};
      end
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_pq     <= '0;
      r_opd    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_pq     <= {{W{1'b0}}, i_a_mag};
      r_opd    <= i_b_mag;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_pq     <= w_pq;
    end
  end

  assign o_pq = r_pq;

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multiply/divide unit: operand forwarding and capture,
// sign handling, IDLE/CALC/DONE sequencing around md_iter_core.
module exe_muldiv_unit
  import multicore_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned NUM_FWD        = 2,
  parameter int unsigned BITS_PER_CYCLE = MD_BITS_PER_CYCLE
) (
  input  logic                              i_aclk,
  input  logic                              i_areset_n,
  input  logic                              i_en,
  input  logic                              i_flush,
  input  logic                              i_valid,
  input  t_mdop                             i_mdop,
  input  logic [$clog2(NUM_REGS)-1:0]       i_rdest,
  input  logic [$clog2(NUM_FWD+1)-1:0]      i_fwd_a,
  input  logic [$clog2(NUM_FWD+1)-1:0]      i_fwd_b,
  input  logic [DATA_SIZE-1:0]              i_op1,
  input  logic [DATA_SIZE-1:0]              i_op2,
  input  logic [NUM_FWD*DATA_SIZE-1:0]      i_fwd_data,
  output logic                              o_busy,
  output logic                              o_valid,
  output logic [DATA_SIZE-1:0]              o_result,
  output logic [$clog2(NUM_REGS)-1:0]       o_rdest
);

  localparam int unsigned W      = DATA_SIZE;
  localparam int unsigned FW     = $clog2(NUM_FWD+1);
  localparam int unsigned RW     = $clog2(NUM_REGS);
  localparam int unsigned N_ITER = DATA_SIZE / BITS_PER_CYCLE;
  localparam int unsigned CW     = $clog2(N_ITER+1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  t_md_state      r_state, w_state_nxt;
  t_mdop          r_op;
  logic           r_neg;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_result;
  logic [RW-1:0]  r_rdest;

  logic [W-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic           w_sa, w_sb, w_neg;
  logic           w_div0, w_ovf, w_special, w_accept, w_step, w_finish;
  logic [W-1:0]   w_special_res, w_final;
  logic [2*W-1:0] w_pq, w_prod_fix;

  always_comb begin
    w_a = i_op1;
    w_b = i_op2;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (i_fwd_a == FW'(k+1)) w_a = i_fwd_data[k*W +: W];
      if (i_fwd_b == FW'(k+1)) w_b = i_fwd_data[k*W +: W];
    end
  end

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    unique case (i_mdop)
      MD_MULH, MD_DIV, MD_REM: begin w_sa = w_a[W-1]; w_sb = w_b[W-1]; end
      MD_MULHSU:               w_sa = w_a[W-1];
      default:                 ;
    endcase
    w_neg   = (i_mdop == MD_REM) ? w_sa : (w_sa ^ w_sb);
    w_a_mag = w_sa ? (~w_a + 1'b1) : w_a;
    w_b_mag = w_sb ? (~w_b + 1'b1) : w_b;
  end

  // Divide-by-zero and signed overflow finish straight from IDLE.
  assign w_div0    = md_is_div(i_mdop) && (w_b == '0);
  assign w_ovf     = md_is_div(i_mdop) && !i_mdop[0] && (w_a == MOST_NEG) && (w_b == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (i_mdop[1] ? w_a : '1)
                                : (i_mdop[1] ? '0  : MOST_NEG);

  assign w_accept = (r_state == MD_IDLE) && i_valid && i_en && !i_flush;
  assign w_step   = (r_state == MD_CALC) && !i_flush && (r_cnt != '0);
  assign w_finish = (r_state == MD_CALC) && !i_flush && (r_cnt == '0);

  md_iter_core #(
    .DATA_SIZE      (DATA_SIZE),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_is_div   (md_is_div(i_mdop)),
    .i_a_mag    (w_a_mag),
    .i_b_mag    (w_b_mag),
    .o_pq       (w_pq)
  );

  always_comb begin
    w_prod_fix = r_neg ? (~w_pq + 1'b1) : w_pq;
    unique case (r_op)
      MD_MUL:                      w_final = w_pq[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:             w_final = r_neg ? (~w_pq[W-1:0] + 1'b1) : w_pq[W-1:0];
      default:                     w_final = r_neg ? (~w_pq[2*W-1:W] + 1'b1) : w_pq[2*W-1:W];
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) r_state <= MD_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_special ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (i_flush)            w_state_nxt = MD_IDLE;
        else if (r_cnt == '0)   w_state_nxt = MD_DONE;
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == MD_CALC) || w_accept;
    o_valid = (r_state == MD_DONE);
  end

  // Counter runs to zero, then one extra CALC cycle applies the sign fix-up.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rdest  <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= i_mdop;
        r_neg   <= w_neg;
        r_rdest <= i_rdest;
        r_cnt   <= w_special ? '0 : CW'(N_ITER);
        if (w_special) r_result <= w_special_res;
      end else if (i_flush) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) r_result <= w_final;
    end
  end

  assign o_result = r_result;
  assign o_rdest  = r_rdest;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed-vector bench for exe_muldiv_unit with hand-computed results,
// latencies, flush, forwarding and mid-operation reset scenarios.
module tb_exe_muldiv_unit;
  import multicore_pkg::*;

  localparam int unsigned LAT_CALC = 33;
  localparam int unsigned LAT_SPEC = 0;

  logic        i_aclk;
  logic        i_areset_n;
  logic        i_en;
  logic        i_flush;
  logic        i_valid;
  t_mdop       i_mdop;
  logic [4:0]  i_rdest;
  logic [1:0]  i_fwd_a;
  logic [1:0]  i_fwd_b;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [63:0] i_fwd_data;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rdest;

  int n_checks;
  int n_errors;
  logic [31:0] last_result;

  typedef struct {
    t_mdop       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } t_vec;

  t_vec vecs [0:17];

  exe_muldiv_unit #(
    .DATA_SIZE      (32),
    .NUM_FWD        (2),
    .BITS_PER_CYCLE (1)
  ) dut (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_en       (i_en),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_mdop     (i_mdop),
    .i_rdest    (i_rdest),
    .i_fwd_a    (i_fwd_a),
    .i_fwd_b    (i_fwd_b),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .i_fwd_data (i_fwd_data),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rdest    (o_rdest)
  );

  initial i_aclk = 1'b0;
  always #5 i_aclk = ~i_aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one op at a negedge, scrambles all inputs after the accepting
  // edge, then measures edges until o_valid (0 = valid right after accept).
  task automatic run_op(input string tag, input t_mdop op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] fa,
                        input logic [63:0] fd, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_low;
    @(negedge i_aclk);
    i_valid = 1'b1; i_mdop = op; i_op1 = a; i_op2 = b;
    i_fwd_a = fa; i_fwd_b = 2'd0; i_fwd_data = fd; i_rdest = rd;
    #1 check({tag, "_busy_idle"}, {31'd0, o_busy}, 32'd1);
    @(posedge i_aclk);
    #1;
    i_valid = 1'b0; i_mdop = MD_REMU; i_op1 = $urandom; i_op2 = $urandom;
    i_fwd_data = {$urandom, $urandom}; i_rdest = 5'(~rd);
    lat = 0;
    busy_low = 0;
    while (o_valid !== 1'b1 && lat < 100) begin
      if (o_busy !== 1'b1) busy_low++;
      @(posedge i_aclk);
      #1;
      lat++;
    end
    check({tag, "_valid"},  {31'd0, o_valid}, 32'd1);
    check({tag, "_busyoff"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_lat"},    32'(lat), 32'(exp_lat));
    check({tag, "_result"}, o_result, exp);
    check({tag, "_rdest"},  {27'd0, o_rdest}, {27'd0, rd});
    check({tag, "_busycalc"}, 32'(busy_low), 32'd0);
    @(posedge i_aclk);
    #1;
    check({tag, "_pulse"},  {31'd0, o_valid}, 32'd0);
    check({tag, "_hold"},   o_result, exp);
    last_result = exp;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_result = '0;
    i_areset_n = 1'b0; i_en = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
    i_mdop = MD_MUL; i_rdest = '0; i_fwd_a = '0; i_fwd_b = '0;
    i_op1 = '0; i_op2 = '0; i_fwd_data = '0;

    vecs[0]  = '{MD_MUL,    32'd7,        32'd6,        32'd42,       LAT_CALC};
    vecs[1]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_CALC};
    vecs[2]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_CALC};
    vecs[3]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_CALC};
    vecs[4]  = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPEC};
    vecs[5]  = '{MD_REMU,   32'd5,        32'd0,        32'd5,        LAT_SPEC};
    vecs[6]  = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPEC};
    vecs[7]  = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_SPEC};
    vecs[8]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_CALC};
    vecs[9]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_CALC};
    vecs[10] = '{MD_MUL,    32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, LAT_CALC};
    vecs[11] = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       LAT_CALC};
    vecs[12] = '{MD_REMU,   32'd100,      32'd7,        32'd2,        LAT_CALC};
    vecs[13] = '{MD_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        LAT_CALC};
    vecs[14] = '{MD_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_SPEC};
    vecs[15] = '{MD_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, LAT_CALC};
    vecs[16] = '{MD_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LAT_CALC};
    vecs[17] = '{MD_DIV,    32'h80000000, 32'd2,        32'hC0000000, LAT_CALC};

    #23;
    check("rst_valid",  {31'd0, o_valid}, 32'd0);
    check("rst_busy",   {31'd0, o_busy},  32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_rdest",  {27'd0, o_rdest}, 32'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;

    for (int v = 0; v < 18; v++)
      run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].b, 2'd0,
             {$urandom, $urandom}, 5'(v + 1), vecs[v].exp, vecs[v].lat);

    // Forwarded operand A = fwd_data[1] = 9 (op1 = 3 must be ignored).
    run_op("fwd", MD_MUL, 32'd3, 32'd2, 2'd2, {32'd9, 32'd77}, 5'd20, 32'd18, LAT_CALC);

    // Flush at CALC cycle 10, then immediate re-issue.
    @(negedge i_aclk);
    i_valid = 1'b1; i_mdop = MD_MUL; i_op1 = 32'd11; i_op2 = 32'd13;
    i_fwd_a = 2'd0; i_rdest = 5'd9;
    @(posedge i_aclk);
    #1 i_valid = 1'b0;
    repeat (9) @(posedge i_aclk);
    @(negedge i_aclk);
    i_flush = 1'b1;
    @(posedge i_aclk);
    #1 i_flush = 1'b0;
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    check("flush_busy",  {31'd0, o_busy},  32'd0);
    check("flush_hold",  o_result, last_result);
    run_op("postflush", MD_DIVU, 32'd1000, 32'd10, 2'd0, 64'd0, 5'd3, 32'd100, LAT_CALC);

    // Flush coinciding with a request in IDLE blocks acceptance.
    @(negedge i_aclk);
    i_valid = 1'b1; i_flush = 1'b1; i_mdop = MD_DIVU; i_op1 = 32'd4; i_op2 = 32'd0;
    #1 check("flushacc_busy", {31'd0, o_busy}, 32'd0);
    @(posedge i_aclk);
    #1 i_valid = 1'b0; i_flush = 1'b0;
    check("flushacc_valid", {31'd0, o_valid}, 32'd0);
    check("flushacc_hold",  o_result, last_result);

    // Reset in the middle of CALC abandons the operation.
    @(negedge i_aclk);
    i_valid = 1'b1; i_mdop = MD_MUL; i_op1 = 32'd5; i_op2 = 32'd5; i_rdest = 5'd7;
    @(posedge i_aclk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge i_aclk);
    #2 i_areset_n = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, o_busy},  32'd0);
    check("midrst_result", o_result, 32'd0);
    check("midrst_rdest",  {27'd0, o_rdest}, 32'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    begin
      int stray;
      stray = 0;
      repeat (40) begin
        @(posedge i_aclk);
        #1 if (o_valid === 1'b1) stray++;
      end
      check("midrst_novalid", 32'(stray), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
